// File: rtl/cmd_issuer_pkg.sv
// Shared definitions for the display command issuer.
//   CMD_SYNC_BYTE : frame sync marker preceding every 4-byte payload
//   CMD_WORD_W    : assembled command word width
//   CMD_BYTES     : payload bytes per frame
//   rx_state_t    : receive framer state encoding
package cmd_issuer_pkg;

  localparam logic [7:0] CMD_SYNC_BYTE = 8'hA5;
  localparam int         CMD_WORD_W    = 32;
  localparam int         CMD_BYTES     = 4;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_B3   = 3'd4,
    ST_PUSH = 3'd5
  } rx_state_t;

  function automatic logic is_payload(input rx_state_t s);
    return (s == ST_B0) || (s == ST_B1) || (s == ST_B2) || (s == ST_B3);
  endfunction

endpackage

// File: rtl/cmd_issuer_if.sv
// Host byte stream and render-side command strobe bundled together.
//   byte_data/byte_valid : host -> issuer, byte offered this cycle
//   byte_ready           : issuer -> host, byte taken when valid & ready
//   cmd_clk/cmd_data     : issuer -> render block, one-cycle command strobe
// modport master : host / render side (test environment)
// modport slave  : cmd_issuer
interface cmd_issuer_if;
  import cmd_issuer_pkg::*;

  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  cmd_clk;
  logic [CMD_WORD_W-1:0] cmd_data;

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, cmd_clk, cmd_data
  );

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, cmd_clk, cmd_data
  );

endinterface

// File: rtl/cmd_issuer_fifo.sv
// cmd_fifo: synchronous FIFO for assembled command words.
//   i_clk/i_rst       : clock, synchronous active-high reset (flushes)
//   i_push/i_wdata    : write request; ignored when full unless popping
//   i_pop/o_rdata     : o_rdata is the head; i_pop removes it
//   o_full/o_empty    : status
//   o_level           : words held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/cmd_issuer.sv
// cmd_issuer: assembles framed host bytes (A5, b0, b1, b2, b3) into 32-bit
// command words, buffers them and issues each as a one-cycle strobe.
//   i_pix_clk     : sole clock
//   i_rst         : synchronous active-high reset
//   bus           : byte stream in, command strobe out (cmd_issuer_if.slave)
//   i_blank       : display blanking, 1 = outside active video
//   i_clr_status  : clears the sticky flags (a same-cycle set wins)
//   o_fifo_level  : words buffered
//   o_overflow    : sticky, a complete frame was dropped on a full FIFO
//   o_frame_err   : sticky, a partial frame was discarded by timeout
// Build option: CMD_BLANK_GATE_EN restricts strobes to i_blank = 1.
//
// state   | meaning
// --------+-----------------------------------------------
// HUNT    | discarding bytes until the sync byte A5
// B0..B3  | collecting payload byte 0..3 (LSB first)
// PUSH    | one cycle writing the word; byte_ready low
module cmd_issuer
  import cmd_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ISSUE_GAP   = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic         i_pix_clk,
  input  logic         i_rst,
  cmd_issuer_if.slave  bus,
  input  logic         i_blank,
  input  logic         i_clr_status,
  output logic [6:0]   o_fifo_level,
  output logic         o_overflow,
  output logic         o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic [CMD_WORD_W-1:0] r_word;
  logic [TW-1:0]         r_idle;
  logic [7:0]            r_gap;
  logic [CMD_WORD_W-1:0] r_cmd_last;
  logic                  r_overflow;
  logic                  r_frame_err;
  logic                  w_accept;
  logic                  w_payload;
  logic                  w_timeout;
  logic                  w_push;
  logic                  w_fire;
  logic                  w_drop;
  logic                  w_gate;
  logic                  w_full;
  logic                  w_empty;
  logic [CMD_WORD_W-1:0] w_head;
  logic [LW-1:0]         w_level;

`ifdef CMD_BLANK_GATE_EN
  assign w_gate = i_blank;
`else
  logic w_unused_blank;
  assign w_unused_blank = i_blank;
  assign w_gate         = 1'b1;
`endif

  assign bus.byte_ready = (r_state != ST_PUSH);
  assign w_accept       = bus.byte_valid & bus.byte_ready;
  assign w_payload      = is_payload(r_state);
  assign w_timeout      = w_payload & ~w_accept & (r_idle == '0);

  // Reset is gated in so a stale non-empty FIFO cannot strobe during reset.
  assign w_fire = ~i_rst & ~w_empty & (r_gap == 8'd0) & w_gate;
  assign w_drop = w_push & w_full & ~w_fire;

  assign bus.cmd_clk  = w_fire;
  assign bus.cmd_data = w_fire ? w_head : r_cmd_last;
  assign o_fifo_level = 7'(w_level);
  assign o_overflow   = r_overflow;
  assign o_frame_err  = r_frame_err;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) r_state <= ST_HUNT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_HUNT: if (w_accept && bus.byte_data == CMD_SYNC_BYTE) w_state_nxt = ST_B0;
      ST_B0:   if (w_accept) w_state_nxt = ST_B1; else if (w_timeout) w_state_nxt = ST_HUNT;
      ST_B1:   if (w_accept) w_state_nxt = ST_B2; else if (w_timeout) w_state_nxt = ST_HUNT;
      ST_B2:   if (w_accept) w_state_nxt = ST_B3; else if (w_timeout) w_state_nxt = ST_HUNT;
      ST_B3:   if (w_accept) w_state_nxt = ST_PUSH; else if (w_timeout) w_state_nxt = ST_HUNT;
      ST_PUSH: begin
        w_push      = 1'b1;
        w_state_nxt = ST_HUNT;
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      r_word      <= '0;
      r_idle      <= '0;
      r_gap       <= '0;
      r_cmd_last  <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // Bytes shift in from the top so b0 ends up in the low byte.
      if (w_accept && w_payload) r_word <= {bus.byte_data, r_word[CMD_WORD_W-1:8]};

      if (w_accept)                       r_idle <= TW'(TIMEOUT_CYC - 1);
      else if (w_payload && r_idle != '0) r_idle <= r_idle - TW'(1);

      if (w_fire)              r_gap <= 8'(ISSUE_GAP - 1);
      else if (r_gap != 8'd0)  r_gap <= r_gap - 8'd1;

      if (w_fire) r_cmd_last <= w_head;

      r_overflow  <= w_drop    | (r_overflow  & ~i_clr_status);
      r_frame_err <= w_timeout | (r_frame_err & ~i_clr_status);
    end
  end

  cmd_fifo #(
    .WIDTH (CMD_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_pix_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (r_word),
    .i_pop   (w_fire),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

endmodule

// File: tb/tb_cmd_issuer.sv
// Testbench for cmd_issuer: randomized byte stream against a frame-level
// reference model; a monitor on the falling edge predicts and checks every
// strobe, the FIFO level and the sticky flags. Honours CMD_BLANK_GATE_EN.
module tb_cmd_issuer;
  import cmd_issuer_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int TMO   = 24;
`ifdef CMD_BLANK_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blank = 1'b0;
  logic       clr = 1'b0;
  logic [6:0] level;
  logic       ovf;
  logic       ferr;

  cmd_issuer_if bus();

  cmd_issuer #(.FIFO_DEPTH(DEPTH), .ISSUE_GAP(GAP), .TIMEOUT_CYC(TMO)) dut (
    .i_pix_clk    (clk),
    .i_rst        (rst),
    .bus          (bus),
    .i_blank      (blank),
    .i_clr_status (clr),
    .o_fifo_level (level),
    .o_overflow   (ovf),
    .o_frame_err  (ferr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: queue of buffered words and frame progress
  logic [31:0] mq[$];
  int          m_nb = -1;      // -1 hunting, 0..3 bytes collected, 4 push pending
  logic [7:0]  m_bytes[4];
  int          m_idle = 0;
  bit          m_ov = 0, m_fe = 0;
  longint      m_cyc = 0, m_last = -1000;
  logic [31:0] m_last_data = '0;

  int blank_mode = 1;  // 0 hold low, 1 hold high, 2 random
  bit clr_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit e_fire, e_ready, acc, set_ov, set_fe;
    if (rst) begin
      check("rst_no_strobe", 32'(bus.cmd_clk), 32'd0);
      mq.delete();
      m_nb = -1; m_idle = 0; m_ov = 0; m_fe = 0;
      m_last = -1000; m_last_data = '0;
    end else begin
      set_ov  = 0;
      set_fe  = 0;
      e_ready = (m_nb != 4);
      e_fire  = (mq.size() > 0) && (m_cyc - m_last >= GAP) && (!GATE || blank);
      check("fifo_level", 32'(level), 32'(mq.size()));
      check("overflow", 32'(ovf), 32'(m_ov));
      check("frame_err", 32'(ferr), 32'(m_fe));
      if (bus.byte_valid) check("byte_ready", 32'(bus.byte_ready), 32'(e_ready));
      if (e_fire || bus.cmd_clk) check("strobe", 32'(bus.cmd_clk), 32'(e_fire));
      if (e_fire && bus.cmd_clk) check("cmd_data", bus.cmd_data, mq[0]);
      else if (!bus.cmd_clk)     check("cmd_data_hold", bus.cmd_data, m_last_data);
      if (e_fire) begin
        m_last_data = mq.pop_front();
        m_last      = m_cyc;
      end
      acc = bus.byte_valid && e_ready;
      if (m_nb == 4) begin
        if (mq.size() < DEPTH) mq.push_back({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
        else set_ov = 1;
        m_nb = -1;
      end else if (m_nb < 0) begin
        if (acc && bus.byte_data == 8'hA5) begin
          m_nb = 0; m_idle = 0;
        end
      end else if (acc) begin
        m_bytes[m_nb] = bus.byte_data;
        m_nb++;
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle >= TMO) begin
          m_nb = -1; set_fe = 1;
        end
      end
      m_ov = set_ov | (m_ov & !clr);
      m_fe = set_fe | (m_fe & !clr);
    end
    m_cyc++;
  end

  always begin
    @(posedge clk); #1;
    blank = (blank_mode == 2) ? 1'($urandom_range(0, 1)) : (blank_mode == 1);
    if (clr_en) clr = ($urandom_range(0, 15) == 0);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    int guard;
    got = 0; guard = 0;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    do begin
      @(negedge clk); got = bus.byte_ready;
      @(posedge clk); #1;
      guard++;
    end while (!got && guard < 20);
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL byte_handshake: ready stayed low for byte %h", b);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w, input int gap_max);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) begin
      if (gap_max > 0) cyc($urandom_range(0, gap_max));
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    blank_mode = 1;
    while ((mq.size() != 0 || m_nb != -1) && g < 3000) begin cyc(1); g++; end
    n_tests++;
    if (g >= 3000) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words still queued", mq.size());
    end
    cyc(2);
  endtask

  initial begin
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;
    rst = 1'b1; cyc(3); rst = 1'b0; cyc(1);
    check("reset_level", 32'(level), 32'd0);
    check("reset_ready", 32'(bus.byte_ready), 32'd1);
    check("reset_data", bus.cmd_data, 32'd0);

    // basic frame
    send_byte(8'hA5); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    drain();
    check("t1_word", bus.cmd_data, 32'h12345678);

    // leading junk ignored
    send_byte(8'h00); send_byte(8'hFF);
    send_frame(32'h04030201, 0);
    drain();
    check("t2_word", bus.cmd_data, 32'h04030201);

    // A5 inside payload is data
    send_frame(32'hA5A5A5A5, 0);
    drain();
    check("payload_sync", bus.cmd_data, 32'hA5A5A5A5);

    // overflow: burst faster than the issue rate (blocked entirely when gated)
    blank_mode = 0;
    for (int i = 0; i < 10; i++) send_frame(32'h1000_0000 + 32'(i), 0);
    cyc(2);
    check("t4_overflow", 32'(ovf), 32'd1);
    check("t4_level_full", 32'(level), 32'(DEPTH));
    clr = 1'b1; cyc(1); clr = 1'b0; cyc(1);
    check("t4_clr", 32'(ovf), 32'd0);
    drain();

    // timeout mid-frame
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
    cyc(TMO + 2);
    check("t5_frame_err", 32'(ferr), 32'd1);
    send_frame(32'hCAFEF00D, 0);
    drain();
    check("t5_word", bus.cmd_data, 32'hCAFEF00D);

    // reset with words queued and a partial frame
    blank_mode = 0;
    for (int i = 0; i < 3; i++) send_frame(32'h2000_0000 + 32'(i), 0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
    check("t6_level", 32'(level), 32'd0);
    check("t6_no_strobe", 32'(bus.cmd_clk), 32'd0);
    blank_mode = 1;
    send_byte(8'hA5); send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    drain();
    check("t6_word", bus.cmd_data, 32'hDEADBEEF);

    // randomized traffic
    blank_mode = 2;
    clr_en = 1;
    for (int f = 0; f < 40; f++) begin
      int junk;
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) send_byte(8'($urandom_range(0, 255)));
      send_frame($urandom, ($urandom_range(0, 7) == 0) ? TMO + 4 : 2);
      cyc($urandom_range(0, 6));
    end
    clr_en = 0;
    clr = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
